// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared period counter and
// CH duty comparators. Supports edge-aligned and center-aligned counting and
// per-channel output polarity. Configuration is double-buffered: a load
// request writes the staging set, and the staging set is copied to the active
// set only at a period boundary, or at any edge while the generator is
// disabled.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         run enable; low holds cnt at 0 and drives outputs inactive
//   period     period value P (CW bits), sampled on load
//   duty       packed duties, channel i at [i*CW +: CW], sampled on load
//   center     0 = edge-aligned, 1 = center-aligned, sampled on load
//   pol        per-channel polarity (1 inverts), sampled on load
//   load       single-cycle request to stage the config inputs
//   pending    staged config is waiting for a boundary
//   upd_done   one-cycle pulse when staging is copied to active
//   cyc_start  one-cycle pulse on the first output cycle of each period
//   pwm_out    registered PWM outputs
module pwm_multi #(
  parameter int CH = 4,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CW-1:0]    period,
  input  logic [CH*CW-1:0] duty,
  input  logic             center,
  input  logic [CH-1:0]    pol,
  input  logic             load,
  output logic             pending,
  output logic             upd_done,
  output logic             cyc_start,
  output logic [CH-1:0]    pwm_out
);

  localparam logic [CW-1:0] ONE = CW'(1);

  // Staging set (written by load)
  logic [CW-1:0]    stg_period;
  logic [CH*CW-1:0] stg_duty;
  logic             stg_center;
  logic [CH-1:0]    stg_pol;

  // Active set (drives counter and comparators)
  logic [CW-1:0]    act_period;
  logic [CH*CW-1:0] act_duty;
  logic             act_center;
  logic [CH-1:0]    act_pol;

  // Counter state; dir_down = 1 while counting down in center mode
  logic [CW-1:0]    cnt;
  logic             dir_down;

  logic [CW-1:0]    cnt_next;
  logic             dir_next;
  logic             boundary;
  logic             apply;
  logic [CH-1:0]    raw;

  // Counter sequencing and period-boundary detection
  always_comb begin
    cnt_next = cnt;
    dir_next = dir_down;
    boundary = 1'b0;
    if (!en) begin
      cnt_next = '0;
      dir_next = 1'b0;
    end else if (act_period == '0) begin
      // P=0: counter parked at 0, every cycle closes a period
      boundary = 1'b1;
      cnt_next = '0;
      dir_next = 1'b0;
    end else if (!act_center) begin
      if (cnt == act_period) begin
        boundary = 1'b1;
        cnt_next = '0;
        dir_next = 1'b0;
      end else begin
        cnt_next = cnt + ONE;
      end
    end else if (!dir_down) begin
      if (cnt == act_period) begin
        if (act_period == ONE) begin
          // P=1 center: sequence is just 0,1 with no down leg
          boundary = 1'b1;
          cnt_next = '0;
          dir_next = 1'b0;
        end else begin
          cnt_next = cnt - ONE;
          dir_next = 1'b1;
        end
      end else begin
        cnt_next = cnt + ONE;
      end
    end else begin
      if (cnt == ONE) begin
        boundary = 1'b1;
        cnt_next = '0;
        dir_next = 1'b0;
      end else begin
        cnt_next = cnt - ONE;
      end
    end
  end

  // Staging is promoted at a boundary, or at any edge while disabled
  assign apply = pending & (boundary | ~en);

  // Per-channel duty comparators on the current count
  always_comb begin
    raw = '0;
    for (int i = 0; i < CH; i++) begin
      raw[i] = (cnt < act_duty[i*CW +: CW]);
    end
  end

  // Counter and direction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      dir_down <= dir_next;
    end
  end

  // Staging registers and pending flag; a load overwrites staging even
  // while pending, so the latest request wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_period <= '0;
      stg_duty   <= '0;
      stg_center <= 1'b0;
      stg_pol    <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        stg_period <= period;
        stg_duty   <= duty;
        stg_center <= center;
        stg_pol    <= pol;
      end
      pending <= load | (pending & ~apply);
    end
  end

  // Active registers, updated only when staging is promoted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_period <= '0;
      act_duty   <= '0;
      act_center <= 1'b0;
      act_pol    <= '0;
    end else if (apply) begin
      act_period <= stg_period;
      act_duty   <= stg_duty;
      act_center <= stg_center;
      act_pol    <= stg_pol;
    end
  end

  // Registered outputs, one cycle behind the count they are derived from
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_done  <= 1'b0;
      cyc_start <= 1'b0;
      pwm_out   <= '0;
    end else begin
      upd_done  <= apply;
      cyc_start <= en & (cnt == '0);
      pwm_out   <= en ? (raw ^ act_pol) : act_pol;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  period;
  logic [31:0] duty;
  logic        center;
  logic [3:0]  pol;
  logic        load;
  logic        pending;
  logic        upd_done;
  logic        cyc_start;
  logic [3:0]  pwm_out;

  int tests = 0;
  int fails = 0;

  pwm_multi #(.CH(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty),
    .center(center), .pol(pol), .load(load), .pending(pending),
    .upd_done(upd_done), .cyc_start(cyc_start), .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] p, input logic [31:0] d,
                         input logic c, input logic [3:0] pl);
    period = p; duty = d; center = c; pol = pl; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Waits for upd_done, then moves to the following cycle (first cyc_start)
  task automatic wait_upd(output bit ok);
    int k;
    ok = 1'b0;
    k = 0;
    while (!ok && k < 64) begin
      if (upd_done) ok = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; period = 8'd0; duty = 32'd0;
    center = 1'b0; pol = 4'd0;
    tick(); tick();
    tests++;
    if ({pending, upd_done, cyc_start, pwm_out} !== 7'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0000000", {pending, upd_done, cyc_start, pwm_out});
    end
    rst = 1'b0; en = 1'b1;
    tick();
    tests++;
    if (cyc_start !== 1'b1 || pwm_out !== 4'd0) begin
      fails++;
      $display("FAIL reset_idle: cyc_start=%b pwm=%b expected 1 0000", cyc_start, pwm_out);
    end
  endtask

  task automatic test_edge();
    logic [19:0] cp, cc;
    do_load(8'd9, 32'h0000_0003, 1'b0, 4'b0000);
    tests++;
    if (pending !== 1'b1 || upd_done !== 1'b0) begin
      fails++;
      $display("FAIL edge_staged: pending=%b upd=%b expected 1 0", pending, upd_done);
    end
    tick();
    tests++;
    if (pending !== 1'b0 || upd_done !== 1'b1) begin
      fails++;
      $display("FAIL edge_apply: pending=%b upd=%b expected 0 1", pending, upd_done);
    end
    tick();
    tests++;
    if (cyc_start !== 1'b1) begin
      fails++;
      $display("FAIL edge_first_cyc: got %b expected 1", cyc_start);
    end
    for (int i = 0; i < 20; i++) begin
      cp[i] = pwm_out[0];
      cc[i] = cyc_start;
      tick();
    end
    tests++;
    if (cp !== 20'h01C07) begin
      fails++;
      $display("FAIL edge_pwm: got %h expected %h", cp, 20'h01C07);
    end
    tests++;
    if (cc !== 20'h00401) begin
      fails++;
      $display("FAIL edge_cyc: got %h expected %h", cc, 20'h00401);
    end
  endtask

  task automatic test_center();
    bit ok;
    logic [15:0] cp, cc;
    do_load(8'd4, 32'h0000_0002, 1'b1, 4'b0000);
    wait_upd(ok);
    tests++;
    if (!ok || cyc_start !== 1'b1) begin
      fails++;
      $display("FAIL center_sync: upd_seen=%0d cyc=%b expected 1 1", ok, cyc_start);
    end
    for (int i = 0; i < 16; i++) begin
      cp[i] = pwm_out[0];
      cc[i] = cyc_start;
      tick();
    end
    tests++;
    if (cp !== 16'h8383) begin
      fails++;
      $display("FAIL center_pwm: got %h expected %h", cp, 16'h8383);
    end
    tests++;
    if (cc !== 16'h0101) begin
      fails++;
      $display("FAIL center_cyc: got %h expected %h", cc, 16'h0101);
    end
  endtask

  task automatic test_extremes();
    bit ok;
    logic [11:0] c0, c1, c2, c3;
    do_load(8'd5, 32'h0105_0600, 1'b0, 4'b0010);
    wait_upd(ok);
    tests++;
    if (!ok || cyc_start !== 1'b1) begin
      fails++;
      $display("FAIL ext_sync: upd_seen=%0d cyc=%b expected 1 1", ok, cyc_start);
    end
    for (int i = 0; i < 12; i++) begin
      c0[i] = pwm_out[0]; c1[i] = pwm_out[1];
      c2[i] = pwm_out[2]; c3[i] = pwm_out[3];
      tick();
    end
    tests++;
    if (c0 !== 12'h000) begin
      fails++;
      $display("FAIL ext_ch0_zero: got %h expected %h", c0, 12'h000);
    end
    tests++;
    if (c1 !== 12'h000) begin
      fails++;
      $display("FAIL ext_ch1_full_inv: got %h expected %h", c1, 12'h000);
    end
    tests++;
    if (c2 !== 12'h7DF) begin
      fails++;
      $display("FAIL ext_ch2_d_eq_p: got %h expected %h", c2, 12'h7DF);
    end
    tests++;
    if (c3 !== 12'h041) begin
      fails++;
      $display("FAIL ext_ch3_one: got %h expected %h", c3, 12'h041);
    end
  endtask

  task automatic test_double_buffer();
    bit ok;
    logic [19:0] cp, cu, cn;
    do_load(8'd9, 32'h0000_0003, 1'b0, 4'b0000);
    wait_upd(ok);
    tests++;
    if (!ok || cyc_start !== 1'b1) begin
      fails++;
      $display("FAIL dbl_sync: upd_seen=%0d cyc=%b expected 1 1", ok, cyc_start);
    end
    for (int i = 0; i < 20; i++) begin
      cp[i] = pwm_out[0];
      cu[i] = upd_done;
      cn[i] = pending;
      if (i == 2) begin duty = 32'h0000_0007; load = 1'b1; end
      else if (i == 4) begin duty = 32'h0000_0002; load = 1'b1; end
      else load = 1'b0;
      tick();
    end
    tests++;
    if (cp !== 20'h00C07) begin
      fails++;
      $display("FAIL dbl_pwm: got %h expected %h", cp, 20'h00C07);
    end
    tests++;
    if (cu !== 20'h00200) begin
      fails++;
      $display("FAIL dbl_upd: got %h expected %h", cu, 20'h00200);
    end
    tests++;
    if (cn !== 20'h001F8) begin
      fails++;
      $display("FAIL dbl_pending: got %h expected %h", cn, 20'h001F8);
    end
  endtask

  task automatic test_boundary_load();
    logic [29:0] cp, cu, cn, cc;
    for (int i = 0; i < 30; i++) begin
      cp[i] = pwm_out[0];
      cu[i] = upd_done;
      cn[i] = pending;
      cc[i] = cyc_start;
      if (i == 8) begin duty = 32'h0000_0005; load = 1'b1; end
      else load = 1'b0;
      tick();
    end
    tests++;
    if (cp !== 30'h01F00C03) begin
      fails++;
      $display("FAIL bnd_pwm: got %h expected %h", cp, 30'h01F00C03);
    end
    tests++;
    if (cn !== 30'h0007FE00) begin
      fails++;
      $display("FAIL bnd_pending: got %h expected %h", cn, 30'h0007FE00);
    end
    tests++;
    if (cu !== 30'h00080000) begin
      fails++;
      $display("FAIL bnd_upd: got %h expected %h", cu, 30'h00080000);
    end
    tests++;
    if (cc !== 30'h00100401) begin
      fails++;
      $display("FAIL bnd_cyc: got %h expected %h", cc, 30'h00100401);
    end
  endtask

  task automatic test_enable();
    logic [5:0] cp, cc;
    for (int i = 0; i < 6; i++) begin
      cp[i] = pwm_out[0];
      cc[i] = cyc_start;
      if (i == 1) en = 1'b0;
      else if (i == 3) en = 1'b1;
      else en = en;
      tick();
    end
    tests++;
    if (cp !== 6'h33) begin
      fails++;
      $display("FAIL en_pwm: got %h expected %h", cp, 6'h33);
    end
    tests++;
    if (cc !== 6'h11) begin
      fails++;
      $display("FAIL en_cyc: got %h expected %h", cc, 6'h11);
    end
  endtask

  task automatic test_async_reset();
    do_load(8'd9, 32'h0000_0004, 1'b0, 4'b0000);
    tests++;
    if (pending !== 1'b1 || pwm_out[0] !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre: pending=%b pwm0=%b expected 1 1", pending, pwm_out[0]);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({pending, upd_done, cyc_start, pwm_out} !== 7'd0) begin
      fails++;
      $display("FAIL arst_clear: got %b expected 0000000", {pending, upd_done, cyc_start, pwm_out});
    end
    tick(); tick();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({cyc_start, pending, upd_done, pwm_out} !== 7'b1000000) begin
        fails++;
        $display("FAIL arst_after_%0d: got %b expected 1000000", i, {cyc_start, pending, upd_done, pwm_out});
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_extremes();
    test_double_buffer();
    test_boundary_load();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator for the animation output stage: one shared period counter drives CH independent duty-cycle comparators. It supports edge-aligned and center-aligned modes and per-channel output polarity. All configuration is double-buffered through a load handshake, so new settings take effect only at a period boundary and glitch-free. It sits between the register/sequencer logic, which issues load requests, and the LED/motor output pins.

## Interface
- CH, default 4: number of PWM channels (1..16).
- CW, default 8: counter, period and duty width in bits (2..16).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; 0 holds the counter at 0 and drives outputs inactive.
- period  in  CW  period value P, sampled on load.
- duty  in  CH*CW  packed per-channel duty D_i; channel i uses bits [i*CW +: CW]. Sampled on load.
- center  in  1  mode, sampled on load; 0 = edge-aligned, 1 = center-aligned.
- pol  in  CH  per-channel polarity, sampled on load; 1 inverts the output.
- load  in  1  single-cycle request to stage the current config inputs.
- pending  out  1  staged config is waiting for a period boundary.
- upd_done  out  1  one-cycle pulse when staged config is copied to active.
- cyc_start  out  1  one-cycle pulse aligned with the first output cycle of each period.
- pwm_out  out  CH  PWM outputs, registered.

## Operation
- Three register sets: staging (written on load), active (used by counter and comparators), and output registers.
- load=1: staging <= inputs; pending <= 1. A load while pending=1 overwrites staging (latest wins), and pending stays 1.
- Edge mode, active period P: cnt runs 0,1,…,P,0,… giving P+1 cycles per period. Raw_i = (cnt < D_i). D_i=0 gives 0%. D_i > P gives 100%.
- Center mode: cnt counts up 0→P, then down P-1→1, then back to 0. Period is 2P cycles, and the dir register tracks direction. Raw_i = (cnt < D_i). The high time is 2·D_i−1 cycles for 1 ≤ D_i ≤ P, 0 for D_i=0, and all 2P cycles for D_i > P.
- P=0 in either mode: cnt stays at 0, every cycle is a period boundary, and raw_i = (D_i > 0).
- Last cycle of a period: cnt==P in edge mode; cnt==1 with dir=down in center mode; every cycle when P=0. At this cycle's clock edge:
  - if pending, active <= staging, pending <= 0, and upd_done pulses next cycle;
  - cnt <= 0 and dir <= up.
- en=0: cnt <= 0 and dir <= up. If pending, staging is copied to active on the next edge. pwm_out <= pol_active (inactive level). cyc_start stays 0.
- pwm_out_i <= raw_i XOR pol_active_i, registered from the current cnt and active config.
- Arithmetic: all comparisons are unsigned at CW bits. No multiply or divide is needed because duty is expressed in counts, not percent.

## Timing
- Reset values:
  - cnt=0, dir=up.
  - All active and staging registers 0, so P=0, D=0, edge mode, pol=0.
  - pending=0, upd_done=0, cyc_start=0, pwm_out=0.
- Reset mid-operation clears everything immediately (asynchronous); any pending load is lost.
- Output latency: pwm_out and cyc_start reflect cnt one cycle later. cyc_start=1 exactly in the output cycle derived from cnt==0 while en=1.
- Load-to-effect: the new config drives pwm_out starting at the first cyc_start after the boundary that clears pending. upd_done asserts in the same cycle as that cnt==0, one cycle before that cyc_start.
- Load asserted in a boundary cycle while pending=0: the value is staged only and applied at the next boundary, not the current one.
- en 1→0 mid-period: the next cycle shows pwm_out inactive and cnt=0.
- en 0→1: cnt=0 is the first counted cycle. cyc_start pulses one cycle later, and a full period follows.
- pending falls in the same cycle upd_done rises.

## Test plan
- Edge mode: load P=9, D_0=3, pol=0, en=1 → period 10 cycles, pwm_out[0] high 3 cycles from each cyc_start, cyc_start every 10 cycles.
- Center mode: load P=4, D_0=2 → period 8, pwm_out[0] high 3 consecutive cycles (cnt 1,0,1) wrapping across the cyc_start boundary.
- Extremes, with P=5, D={0,6,5,1}, pol[1]=1:
  - ch0 always 0;
  - ch1 always 0 (100% inverted);
  - ch2 high 5 of 6 cycles;
  - ch3 high 1 cycle.
- Double-buffer: mid-period load D_0=7, then a second load D_0=2 before the boundary → pending=1 until the boundary, a single upd_done, and the next period uses D_0=2 with no glitch in the current period.
- Load in the boundary cycle → staged only, pending=1 for one full period, applied at the following boundary.
- Async rst asserted mid-period with pending=1 → all outputs 0, pending=0, and after release with en=1 the counter holds at 0 (P=0) until a new load applies.
